// File: rtl/multiport_regfile_pkg.sv
// Shared constants and FSM state type for the multiport_regfile slice.
package multiport_regfile_pkg;

  localparam int DATA_LEN = 32;

  typedef enum logic {
    RF_ST_INIT = 1'b0,
    RF_ST_RUN  = 1'b1
  } rf_state_e;

endpackage

// File: rtl/multiport_regfile_if.sv
// Operand-read / writeback-write bus of the register file; the master side is rename/dispatch + writeback.
interface multiport_regfile_if
  import multiport_regfile_pkg::*;
#(
  parameter int NUM_RD = 6,
  parameter int NUM_WR = 3,
  parameter int ADDR_W = 6,
  parameter int DATA_W = DATA_LEN
);

  logic                       clear_req;
  logic                       ready;
  logic [NUM_RD*ADDR_W-1:0]   raddr;
  logic [NUM_RD*DATA_W-1:0]   rdata;
  logic [NUM_WR-1:0]          we;
  logic [NUM_WR*ADDR_W-1:0]   waddr;
  logic [NUM_WR*DATA_W-1:0]   wdata;

  modport master (
    output clear_req, raddr, we, waddr, wdata,
    input  ready, rdata
  );

  modport slave (
    input  clear_req, raddr, we, waddr, wdata,
    output ready, rdata
  );

endinterface

// File: rtl/multiport_regfile_clear_ctrl.sv
// rf_clear_ctrl: INIT/RUN sequencer that walks every entry writing zero, then holds ready until a clear request.
module rf_clear_ctrl
  import multiport_regfile_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_req,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready
);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              ready_q, ready_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RF_ST_INIT;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_d   = ready_q;
    unique case (state_q)
      RF_ST_INIT: begin
        // DEPTH is a power of two, so the counter wraps back to 0 on the last entry
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = RF_ST_RUN;
          ready_d = 1'b1;
        end
      end
      RF_ST_RUN: begin
        if (clear_req) begin
          state_d   = RF_ST_INIT;
          clr_cnt_d = '0;
          ready_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign clr_we   = (state_q == RF_ST_INIT);
  assign clr_addr = clr_cnt_q;
  assign ready    = ready_q;

endmodule

// File: rtl/multiport_regfile.sv
// multiport_regfile: NUM_RD registered read ports, NUM_WR write ports, self-clearing after reset.
// Define RF_WRITE_BYPASS_EN to forward same-edge write data to matching read ports.
module multiport_regfile
  import multiport_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_LEN,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NUM_RD = 6,
  parameter int NUM_WR = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  multiport_regfile_if.slave bus
);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              ready;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic [ADDR_W-1:0] wr_addr [NUM_WR];
  logic [DATA_W-1:0] wr_data [NUM_WR];

  rf_clear_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_ctrl (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_req (bus.clear_req),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .ready     (ready)
  );

  assign bus.ready = ready;

  for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
    assign wr_addr[j] = bus.waddr[j*ADDR_W +: ADDR_W];
    assign wr_data[j] = bus.wdata[j*DATA_W +: DATA_W];
  end

  // Ascending port order lets the highest-index enabled writer win a shared address
  always_comb begin
    mem_d = mem_q;
    if (clr_we) begin
      mem_d[clr_addr] = '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (bus.we[j]) mem_d[wr_addr[j]] = wr_data[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata_d, rdata_q;

    assign raddr = bus.raddr[i*ADDR_W +: ADDR_W];

    always_comb begin
      rdata_d = mem_q[raddr];
`ifdef RF_WRITE_BYPASS_EN
      for (int j = 0; j < NUM_WR; j++) begin
        if (bus.we[j] && (wr_addr[j] == raddr)) rdata_d = wr_data[j];
      end
`endif
      // Entries not yet cleared must never reach the read ports
      if (clr_we) rdata_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rdata_q <= '0;
      else          rdata_q <= rdata_d;
    end

    assign bus.rdata[i*DATA_W +: DATA_W] = rdata_q;
  end

endmodule

// File: tb/tb_multiport_regfile.sv
// Bench for multiport_regfile: default 6R/3W/64-entry instance against an array model, plus a 2R/1W/16-entry instance.
module tb_multiport_regfile;
  import multiport_regfile_pkg::*;

  localparam int DW    = DATA_LEN;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int NRD   = 6;
  localparam int NWR   = 3;
  localparam int S_DEPTH = 16;
  localparam int S_AW    = 4;
  localparam int S_NRD   = 2;
  localparam int S_NWR   = 1;

  logic clk = 1'b0;
  logic reset_n;
  logic reset_n_s;
  always #5 clk = ~clk;

  multiport_regfile_if #(.NUM_RD(NRD), .NUM_WR(NWR), .ADDR_W(AW), .DATA_W(DW)) bus ();
  multiport_regfile_if #(.NUM_RD(S_NRD), .NUM_WR(S_NWR), .ADDR_W(S_AW), .DATA_W(DW)) bus_s ();

  multiport_regfile #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_RD(NRD), .NUM_WR(NWR)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  multiport_regfile #(.DATA_W(DW), .DEPTH(S_DEPTH), .NUM_RD(S_NRD), .NUM_WR(S_NWR)) dut_s (
    .clk     (clk),
    .reset_n (reset_n_s),
    .bus     (bus_s)
  );

  // Reference model: array contents, ready flag, remaining clear edges, expected read data
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_rd  [NRD];
  bit            m_ready;
  int            m_clr_left;

  int checks = 0;
  int fails  = 0;

  task automatic m_reset();
    foreach (m_mem[k]) m_mem[k] = '0;
    foreach (m_rd[k])  m_rd[k]  = '0;
    m_ready    = 1'b0;
    m_clr_left = DEPTH;
  endtask

  // Applies the rules of one rising edge to the model using the inputs currently on the bus
  task automatic m_edge();
    logic [AW-1:0] a;
    if (!m_ready) begin
      foreach (m_rd[k]) m_rd[k] = '0;
      m_clr_left--;
      if (m_clr_left == 0) m_ready = 1'b1;
    end else begin
      for (int i = 0; i < NRD; i++) begin
        a = bus.raddr[i*AW +: AW];
        m_rd[i] = m_mem[a];
`ifdef RF_WRITE_BYPASS_EN
        for (int j = 0; j < NWR; j++)
          if (bus.we[j] && bus.waddr[j*AW +: AW] == a) m_rd[i] = bus.wdata[j*DW +: DW];
`endif
      end
      for (int j = 0; j < NWR; j++)
        if (bus.we[j]) m_mem[bus.waddr[j*AW +: AW]] = bus.wdata[j*DW +: DW];
      if (bus.clear_req) begin
        m_ready    = 1'b0;
        m_clr_left = DEPTH;
        foreach (m_mem[k]) m_mem[k] = '0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [NRD*DW-1:0] exp_rd;
    for (int i = 0; i < NRD; i++) exp_rd[i*DW +: DW] = m_rd[i];
    checks++;
    assert (bus.ready === m_ready) else begin
      fails++;
      $error("FAIL %s ready: observed %0b expected %0b", tag, bus.ready, m_ready);
    end
    checks++;
    assert (bus.rdata === exp_rd) else begin
      fails++;
      $error("FAIL %s rdata: observed %h expected %h", tag, bus.rdata, exp_rd);
    end
  endtask

  task automatic cycle(input string tag);
    m_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive_idle();
    bus.clear_req = 1'b0;
    bus.raddr     = '0;
    bus.we        = '0;
    bus.waddr     = '0;
    bus.wdata     = '0;
  endtask

  task automatic drive_rand(input int clr_pct);
    for (int i = 0; i < NRD; i++)
      bus.raddr[i*AW +: AW] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7))
                                                          : AW'($urandom_range(0, DEPTH - 1));
    for (int j = 0; j < NWR; j++) begin
      bus.we[j]             = 1'($urandom_range(0, 1));
      bus.waddr[j*AW +: AW] = AW'($urandom_range(0, 7));
      bus.wdata[j*DW +: DW] = DW'($urandom());
    end
    bus.clear_req = ($urandom_range(0, 99) < clr_pct);
  endtask

  task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [DW-1:0] v;

    reset_n   = 1'b0;
    reset_n_s = 1'b0;
    drive_idle();
    bus_s.clear_req = 1'b0;
    bus_s.raddr     = '0;
    bus_s.we        = '0;
    bus_s.waddr     = '0;
    bus_s.wdata     = '0;
    m_reset();
    #12;
    check_all("reset");

    // Reset release, then random traffic (writes and clears ignored) across the whole clear
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int n = 0; n < DEPTH; n++) begin
      drive_rand(30);
      cycle("init_clear");
    end
    check_bit("ready_after_64", bus.ready, 1'b1);

    drive_idle();
    for (int a = 0; a < DEPTH; a++) begin
      for (int i = 0; i < NRD; i++) bus.raddr[i*AW +: AW] = AW'(a);
      cycle("read_all_zero");
    end

    // Three writers collide on address 5
    drive_idle();
    bus.we = 3'b111;
    for (int j = 0; j < NWR; j++) bus.waddr[j*AW +: AW] = AW'(5);
    bus.wdata = {32'h0000_000C, 32'h0000_000B, 32'h0000_000A};
    bus.raddr[0 +: AW] = AW'(5);
    cycle("conflict_same");
`ifdef RF_WRITE_BYPASS_EN
    check_val("same_cycle_read", bus.rdata[0 +: DW], 32'h0000_000C);
`else
    check_val("same_cycle_read", bus.rdata[0 +: DW], 32'h0000_0000);
`endif
    bus.we = '0;
    cycle("conflict_next");
    check_val("conflict_winner", bus.rdata[0 +: DW], 32'h0000_000C);

    // Port 1 write, then every read port on the same entry
    drive_idle();
    bus.we = 3'b010;
    bus.waddr[1*AW +: AW] = AW'(7);
    bus.wdata[1*DW +: DW] = 32'h0000_1234;
    cycle("wr_p1");
    bus.we = '0;
    for (int i = 0; i < NRD; i++) bus.raddr[i*AW +: AW] = AW'(7);
    cycle("rd_all_7");
    for (int i = 0; i < NRD; i++) check_val("all_ports_7", bus.rdata[i*DW +: DW], 32'h0000_1234);

    // Clear request with a write issued during INIT
    drive_idle();
    bus.we = 3'b001;
    bus.waddr[0 +: AW] = AW'(3);
    bus.wdata[0 +: DW] = 32'h0000_00FF;
    bus.raddr[0 +: AW] = AW'(3);
    cycle("wr_ff");
    bus.we = '0;
    cycle("rd_ff");
    check_val("ff_written", bus.rdata[0 +: DW], 32'h0000_00FF);
    bus.clear_req = 1'b1;
    cycle("clear_pulse");
    check_bit("ready_drop", bus.ready, 1'b0);
    bus.clear_req = 1'b0;
    bus.we = 3'b001;
    bus.waddr[0 +: AW] = AW'(9);
    bus.wdata[0 +: DW] = 32'h0000_0099;
    cycle("init_write");
    bus.we = '0;
    for (int n = 0; n < DEPTH - 1; n++) cycle("reclear");
    check_bit("ready_after_reclear", bus.ready, 1'b1);
    bus.raddr[0 +: AW] = AW'(3);
    bus.raddr[1*AW +: AW] = AW'(9);
    cycle("rd_after_clear");
    check_val("addr3_cleared", bus.rdata[0 +: DW], '0);
    check_val("addr9_ignored", bus.rdata[1*DW +: DW], '0);

    // Random traffic with occasional clear requests
    for (int n = 0; n < 400; n++) begin
      drive_rand(2);
      cycle("random_run");
    end
    while (!m_ready) begin
      drive_rand(0);
      cycle("random_drain");
    end
    drive_rand(0);
    cycle("pre_async");

    // Asynchronous reset between edges
    #2;
    reset_n = 1'b0;
    #1;
    m_reset();
    check_all("async_reset");
    @(posedge clk);
    #1;
    check_all("held_reset");
    reset_n = 1'b1;
    for (int n = 0; n < DEPTH; n++) begin
      drive_rand(20);
      cycle("post_rst_clear");
    end
    check_bit("ready_post_rst", bus.ready, 1'b1);
    for (int n = 0; n < 50; n++) begin
      drive_rand(0);
      cycle("post_rst_run");
    end

    // Small build: 16-entry clear, then write/read of the top entry
    reset_n_s = 1'b1;
    for (int k = 1; k <= S_DEPTH; k++) begin
      @(posedge clk);
      #1;
      check_bit("small_ready", bus_s.ready, (k == S_DEPTH));
      check_val("small_rd_init", bus_s.rdata[0 +: DW], '0);
    end
    v = DW'($urandom());
    bus_s.we = 1'b1;
    bus_s.waddr = S_AW'(15);
    bus_s.wdata = v;
    @(posedge clk);
    #1;
    bus_s.we = 1'b0;
    bus_s.raddr[0 +: S_AW] = S_AW'(15);
    bus_s.raddr[S_AW +: S_AW] = S_AW'(14);
    @(posedge clk);
    #1;
    check_val("small_rd_15", bus_s.rdata[0 +: DW], v);
    check_val("small_rd_14", bus_s.rdata[DW +: DW], '0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/multiport_regfile.md
Name: multiport_regfile

Overview:
- Parametrised multi-ported physical register file: NUM_RD synchronous read ports, NUM_WR write ports, DEPTH entries of DATA_W bits.
- Sits between rename/dispatch (operand reads) and the completion/writeback buses (result writes).
- Generalises the fixed 6-read/3-write file:
  - port counts and sizes are parameters;
  - reads are registered on the rising edge;
  - simultaneous writes to one address resolve deterministically;
  - a built-in clear FSM zeroes the array after reset or on request.

Parameters:
- DATA_W, default `DATA_LEN: entry width in bits.
- DEPTH, default 64: number of entries; must be a power of two, at least 2.
- ADDR_W, default $clog2(DEPTH): address width. Derived; do not override.
- NUM_RD, default 6: number of read ports, 1..8.
- NUM_WR, default 3: number of write ports, 1..4.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear_req  in  1  one-cycle pulse; requests a full array clear.
- ready  out  1  high when the array is usable (FSM in RUN).
- raddr  in  NUM_RD*ADDR_W  read addresses; port i uses slice [i*ADDR_W +: ADDR_W].
- rdata  out  NUM_RD*DATA_W  registered read data; port i uses slice [i*DATA_W +: DATA_W].
- we  in  NUM_WR  per-port write enables.
- waddr  in  NUM_WR*ADDR_W  write addresses, packed the same way as raddr.
- wdata  in  NUM_WR*DATA_W  write data, packed the same way as rdata.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=INIT, clr_cnt=0, ready=0, all rdata=0.
  - The array itself is not reset; it is cleared by the FSM.
- FSM states:
  - INIT: each rising edge writes 0 to mem[clr_cnt], then clr_cnt increments.
    - On the edge that clears entry DEPTH-1: state goes to RUN, ready goes to 1 (registered).
    - From reset release to ready=1 takes exactly DEPTH edges.
  - RUN: normal operation.
    - clear_req=1 at an edge: state goes to INIT, clr_cnt=0, ready goes to 0.
    - Writes on that same edge are still performed; they are then overwritten by the clear.
  - clear_req while in INIT: ignored. The clear continues and is not restarted.
- Writes in RUN:
  - At a rising edge, each port j with we[j]=1 writes wdata[j] to mem[waddr[j]].
  - Same-address conflict: the highest-index enabled port wins.
  - Writes in INIT: ignored entirely.
- Reads:
  - Latency 1. At each rising edge, rdata[i] takes mem[raddr[i]] for every port, unconditionally; there is no read enable.
  - Read-during-write (bypass feature compiled out): rdata returns the value held before that edge's writes.
  - In INIT: all rdata load 0 at every edge. Reads of uncleared entries never leak.
- Any number of read ports may address the same entry.
- Addresses are always in range (ADDR_W bits); there is no wrap-around handling.
- Reset asserted mid-clear or mid-operation:
  - Clear restarts from entry 0.
  - Array contents are undefined until the clear completes.
  - Outputs are forced to their reset values immediately.

Optional Feature:
- Macro RF_WRITE_BYPASS_EN.
- Defined:
  - In RUN, if raddr[i] matches waddr[j] with we[j]=1 on the same edge, rdata[i] loads wdata[j] (new data).
  - With several matches, the highest matching j is used, consistent with write priority.
- Undefined: read-old-data semantics, no comparators.
- Either way, INIT still forces rdata to 0.

Decomposition:
- constants.vh:
  - existing `DATA_LEN;
  - new `RF_ST_INIT=1'b0, `RF_ST_RUN=1'b1.
- One sub-module, rf_clear_ctrl:
  - holds the INIT/RUN FSM and clr_cnt;
  - inputs clk, reset_n, clear_req;
  - outputs clr_we, clr_addr, ready.
- Write-priority resolve and the bypass mux stay in generate loops in the top level.

Test Plan:
1. Reset release, DEPTH=64: ready=0 for 64 edges, 1 on the 64th edge. During that time every rdata=0. Afterwards, reading all 64 addresses returns 0.
2. RUN: we=3'b111, all waddr=5, wdata={0xC,0xB,0xA} (ports 2,1,0).
   - Next cycle, raddr0=5 returns 0xC.
   - Same-cycle read: returns the old value (0) without the macro, 0xC with RF_WRITE_BYPASS_EN.
3. Write 0x1234 to addr 7 via port 1. Next edge, all 6 read ports address 7; all return 0x1234.
4. Write 0xFF to addr 3. Pulse clear_req.
   - ready drops the following edge.
   - A write to addr 9 issued during INIT is ignored.
   - After 64 edges, ready=1; addr 3 and addr 9 both read 0.
5. Drop reset_n asynchronously mid-RUN, between edges. rdata=0 and ready=0 immediately. The full 64-cycle clear then repeats.
6. NUM_RD=2, NUM_WR=1, DEPTH=16 build: clear takes 16 edges. A write then read at addr 15 returns the data written.
